dma_req_arbiter: RTL

- Upstream companion to the DMA transfer engine.
- Holds one descriptor per channel (source address, destination address, length, enable); the processor programs these through a simple register write port.
- Arbitrates the channel request lines round-robin, presents the winning descriptor on stable outputs and pulses a start strobe to the engine.
- Waits for the engine's done pulse or a watchdog timeout, then returns a one-cycle acknowledge to the requesting channel.

---
 rtl/dma_pkg.sv | 20 ++
 rtl/dma_req_arbiter_rr_pick.sv | 32 +++
 rtl/dma_req_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared DMA definitions: arbiter state encoding, descriptor register map and
// the default address/length widths shared with the transfer engine.
package dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_ACK   = 2'd3
  } dma_state_e;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int DMA_AW = 8;
  localparam int DMA_LW = 8;

endpackage

// File: rtl/dma_req_arbiter_rr_pick.sv
// Combinational round-robin selector: the eligible channel closest after
// i_last (wrapping modulo NCH) wins.
module rr_pick #(
  parameter int NCH = 2,
  parameter int GW  = 1
)(
  input  logic [NCH-1:0] i_elig,
  input  logic [GW-1:0]  i_last,
  output logic [GW-1:0]  o_win,
  output logic           o_vld
);

  int w_dist;
  int w_best;

  // Distance 0 is the channel right after the last grant, NCH-1 is the last grant itself.
  always_comb begin
    o_win  = '0;
    o_vld  = 1'b0;
    w_best = NCH;
    w_dist = 0;
    for (int i = 0; i < NCH; i++) begin
      w_dist = (i + NCH - 1 - int'(i_last)) % NCH;
      if (i_elig[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_win  = GW'(i);
        o_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_req_arbiter.sv
// Per-channel descriptor file, round-robin grant and start/done/timeout
// handshake in front of the DMA transfer engine.
module dma_req_arbiter
  import dma_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int AW      = DMA_AW,
  parameter int LW      = DMA_LW,
  parameter int TIMEOUT = 255
)(
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_we,
  input  logic [3:0]     cfg_addr,
  input  logic [7:0]     cfg_wdata,
  input  logic [NCH-1:0] dma_req,
  output logic [NCH-1:0] dma_ack,
  output logic           dma_err,
  output logic           xfer_start,
  output logic [AW-1:0]  address_source,
  output logic [AW-1:0]  address_dist,
  output logic [LW-1:0]  length,
  input  logic           xfer_done,
  output logic           busy
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TB = $clog2(TIMEOUT + 1);
  localparam int TW = (TB > 8) ? TB : 8;

  logic [NCH-1:0][AW-1:0] r_src, r_dst;
  logic [NCH-1:0][LW-1:0] r_len;
  logic [NCH-1:0]         r_en;

  dma_state_e    r_state, w_state_n;
  logic [GW-1:0] r_grant, r_last, w_win;
  logic          w_vld;
  logic [TW-1:0] r_timer, w_timer_n, w_tinc;
  logic          r_err, w_err_n;
  logic [AW-1:0] r_src_o, r_dst_o;
  logic [LW-1:0] r_len_o;
  logic [NCH-1:0] w_elig;

  assign w_elig = dma_req & r_en;

  rr_pick #(.NCH(NCH), .GW(GW)) u_pick (
    .i_elig (w_elig),
    .i_last (r_last),
    .o_win  (w_win),
    .o_vld  (w_vld)
  );

  // Writes to channels >= NCH match no loop index and fall through silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
      r_en  <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_addr[3:2] == 2'(i)) begin
          case (cfg_addr[1:0])
            REG_SRC:  r_src[i] <= AW'(cfg_wdata);
            REG_DST:  r_dst[i] <= AW'(cfg_wdata);
            REG_LEN:  r_len[i] <= LW'(cfg_wdata);
            REG_CTRL: r_en[i]  <= cfg_wdata[0];
          endcase
        end
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer;
    w_err_n   = r_err;
    w_tinc    = r_timer + TW'(1);
    case (r_state)
      S_IDLE: begin
        if (w_vld) begin
          w_err_n   = 1'b0;
          w_state_n = (r_len[w_win] == '0) ? S_ACK : S_START;
        end
      end
      S_START: begin
        w_timer_n = '0;
        w_state_n = S_BUSY;
      end
      S_BUSY: begin
        w_timer_n = w_tinc;
        if (xfer_done) begin
          w_state_n = S_ACK;
        end else if (w_tinc == TW'(TIMEOUT)) begin
          w_err_n   = 1'b1;
          w_state_n = S_ACK;
        end
      end
      S_ACK:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Descriptor outputs are snapshotted at grant; later cfg writes only touch the file.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= GW'(NCH - 1);
      r_timer <= '0;
      r_err   <= 1'b0;
      r_src_o <= '0;
      r_dst_o <= '0;
      r_len_o <= '0;
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_err   <= w_err_n;
      if ((r_state == S_IDLE) && w_vld) begin
        r_grant <= w_win;
        r_src_o <= r_src[w_win];
        r_dst_o <= r_dst[w_win];
        r_len_o <= r_len[w_win];
      end
      if (r_state == S_ACK) r_last <= r_grant;
    end
  end

  assign xfer_start     = (r_state == S_START) && !reset;
  assign dma_ack        = (r_state == S_ACK) ? (NCH'(1) << r_grant) : '0;
  assign dma_err        = (r_state == S_ACK) && r_err;
  assign busy           = (r_state != S_IDLE);
  assign address_source = r_src_o;
  assign address_dist   = r_dst_o;
  assign length         = r_len_o;

endmodule
